// File: rtl/gray_code_converter.sv
// Binary<->Gray converter for CDC pointers: combinational encode/decode, registered copies,
// and registered self-checks for round-trip mismatch and multi-bit Gray steps.
module gray_code_converter #(
    parameter int unsigned N = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] bin_i,
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] gray_o,
    output logic [N-1:0] bin_o,
    output logic [N-1:0] gray_q_o,
    output logic [N-1:0] bin_q_o,
    output logic         rt_err_o,
    output logic         step_err_o
);

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int k = int'(N) - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [N-1:0] gray_q, gray_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] prev_gray_q, prev_gray_d;
    logic         seen_q, seen_d;
    logic         rt_err_q, rt_err_d;
    logic         step_err_q, step_err_d;

    logic [N-1:0] step_diff;
    logic         rt_mismatch;
    logic         multi_bit_step;

    always_comb begin
        gray_o = bin2gray(bin_i);
        bin_o  = gray2bin(gray_i);
    end

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    always_comb begin
        step_diff      = gray_o ^ prev_gray_q;
        multi_bit_step = |(step_diff & (step_diff - N'(1)));
        rt_mismatch    = (gray2bin(gray_o) != bin_i);
    end

    always_comb begin
        gray_d      = gray_q;
        bin_d       = bin_q;
        prev_gray_d = prev_gray_q;
        seen_d      = seen_q;
        rt_err_d    = rt_err_q;
        step_err_d  = step_err_q;
        if (en_i) begin
            gray_d      = gray_o;
            bin_d       = bin_o;
            prev_gray_d = gray_o;
            seen_d      = 1'b1;
            rt_err_d    = rt_mismatch;
            step_err_d  = seen_q & multi_bit_step;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gray_q      <= '0;
            bin_q       <= '0;
            prev_gray_q <= '0;
            seen_q      <= 1'b0;
            rt_err_q    <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            gray_q      <= gray_d;
            bin_q       <= bin_d;
            prev_gray_q <= prev_gray_d;
            seen_q      <= seen_d;
            rt_err_q    <= rt_err_d;
            step_err_q  <= step_err_d;
        end
    end

    always_comb begin
        gray_q_o   = gray_q;
        bin_q_o    = bin_q;
        rt_err_o   = rt_err_q;
        step_err_o = step_err_q;
    end

endmodule

// File: tb/tb_gray_code_converter.sv
// Directed bench for gray_code_converter at N=9.
module tb_gray_code_converter;

    localparam int unsigned N = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [N-1:0] bin_in  = '0;
    logic [N-1:0] gray_in = '0;
    logic [N-1:0] gray_out, bin_out, gray_q, bin_q;
    logic         rt_err, step_err;

    int checks = 0;
    int errors = 0;

    gray_code_converter #(.N(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .bin_i      (bin_in),
        .gray_i     (gray_in),
        .gray_o     (gray_out),
        .bin_o      (bin_out),
        .gray_q_o   (gray_q),
        .bin_q_o    (bin_q),
        .rt_err_o   (rt_err),
        .step_err_o (step_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; rst = 1'b1; bin_in = 9'd300; gray_in = 9'd77;
        tick();
        rst = 1'b0; en = 1'b0;
        checks++; if (gray_q !== 9'd0) begin errors++; $display("FAIL reset_gray_q got %0d want 0", gray_q); end
        checks++; if (bin_q !== 9'd0) begin errors++; $display("FAIL reset_bin_q got %0d want 0", bin_q); end
        checks++; if (rt_err !== 1'b0) begin errors++; $display("FAIL reset_rt_err got %b want 0", rt_err); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b want 0", step_err); end
    endtask

    task automatic test_directed();
        logic [N-1:0] b_vec [4] = '{9'd5, 9'd511, 9'd300, 9'd1};
        logic [N-1:0] g_vec [4] = '{9'd7, 9'd256, 9'd442, 9'd1};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bin_in = b_vec[i]; gray_in = g_vec[i];
            #1;
            checks++; if (gray_out !== g_vec[i]) begin errors++; $display("FAIL encode[%0d] got %0d want %0d", i, gray_out, g_vec[i]); end
            checks++; if (bin_out !== b_vec[i]) begin errors++; $display("FAIL decode[%0d] got %0d want %0d", i, bin_out, b_vec[i]); end
            tick();
            checks++; if (gray_q !== g_vec[i]) begin errors++; $display("FAIL gray_q[%0d] got %0d want %0d", i, gray_q, g_vec[i]); end
            checks++; if (bin_q !== b_vec[i]) begin errors++; $display("FAIL bin_q[%0d] got %0d want %0d", i, bin_q, b_vec[i]); end
        end
    endtask

    task automatic test_round_trip();
        logic [N-1:0] v, g;
        en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            v = N'(i);
            g = v ^ (v >> 1);
            bin_in = v; gray_in = g;
            #1;
            checks++; if (gray_out !== g) begin errors++; $display("FAIL rt_encode v=%0d got %0d want %0d", v, gray_out, g); end
            checks++; if (bin_out !== v) begin errors++; $display("FAIL rt_decode g=%0d got %0d want %0d", g, bin_out, v); end
            tick();
            checks++; if (rt_err !== 1'b0) begin errors++; $display("FAIL rt_err v=%0d got %b want 0", v, rt_err); end
        end
    endtask

    task automatic run_count(input int start, input int dir, input int len, input string name);
        logic [N-1:0] v, g, pg;
        int pc_now, pc_prev;
        rst = 1'b1; en = 1'b0; tick(); rst = 1'b0; en = 1'b1;
        pg = '0;
        for (int i = 0; i < len; i++) begin
            v = N'(start + dir * i);
            g = v ^ (v >> 1);
            bin_in = v;
            tick();
            checks++; if (gray_q !== g) begin errors++; $display("FAIL %s_gray_q v=%0d got %0d want %0d", name, v, gray_q, g); end
            checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL %s_step_err v=%0d got %b want 0", name, v, step_err); end
            if (i > 0) begin
                pc_now = $countones(gray_q); pc_prev = $countones(pg);
                checks++;
                if ($countones(gray_q ^ pg) != 1 || (pc_now - pc_prev > 1) || (pc_prev - pc_now > 1)) begin
                    errors++; $display("FAIL %s_one_bit v=%0d got %0d prev %0d want distance 1", name, v, gray_q, pg);
                end
            end
            pg = gray_q;
        end
    endtask

    task automatic test_count_up();
        run_count(0, 1, 1024, "up");
    endtask

    task automatic test_count_down();
        run_count(8, -1, 40, "down");
    endtask

    task automatic test_step_violation();
        rst = 1'b1; en = 1'b0; tick(); rst = 1'b0; en = 1'b1;
        bin_in = 9'd0; tick();
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL viol_first got %b want 0", step_err); end
        bin_in = 9'd5; tick();
        checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL viol_jump got %b want 1", step_err); end
        bin_in = 9'd4; tick();
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL viol_recover got %b want 0", step_err); end
        bin_in = 9'd4; tick();
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL viol_repeat got %b want 0", step_err); end
    endtask

    task automatic test_hold();
        en = 1'b1; bin_in = 9'd5; gray_in = 9'd7; tick();
        bin_in = 9'd0; tick();
        bin_in = 9'd5; tick();  // gray 0 -> 7 leaves step_err set
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bin_in = N'(100 + 37 * i); gray_in = N'(200 + 11 * i);
            tick();
            checks++; if (gray_q !== 9'd7) begin errors++; $display("FAIL hold_gray_q got %0d want 7", gray_q); end
            checks++; if (bin_q !== 9'd5) begin errors++; $display("FAIL hold_bin_q got %0d want 5", bin_q); end
            checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL hold_step_err got %b want 1", step_err); end
        end
        // prev_gray must also have held at 7: 7 -> 6 is a single-bit step
        en = 1'b1; bin_in = 9'd4; tick();
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL hold_prev got %b want 0", step_err); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        for (int i = 40; i < 45; i++) begin bin_in = N'(i); tick(); end
        rst = 1'b1; bin_in = 9'd200; tick();
        checks++; if (gray_q !== 9'd0) begin errors++; $display("FAIL mid_gray_q got %0d want 0", gray_q); end
        checks++; if (bin_q !== 9'd0) begin errors++; $display("FAIL mid_bin_q got %0d want 0", bin_q); end
        rst = 1'b0; bin_in = 9'd300; gray_in = 9'd442; tick();
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL mid_first got %b want 0", step_err); end
        checks++; if (gray_q !== 9'd442) begin errors++; $display("FAIL mid_gray_q2 got %0d want 442", gray_q); end
        checks++; if (bin_q !== 9'd300) begin errors++; $display("FAIL mid_bin_q2 got %0d want 300", bin_q); end
        bin_in = 9'd5; tick();
        checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL mid_after got %b want 1", step_err); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_trip();
        test_count_up();
        test_count_down();
        test_step_violation();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
